// File: rtl/data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_sync
// Purpose  : MEM-stage data memory with byte/half/word access, registered load
//            responses and a post-reset clear sweep.
//            Optional macro DMEM_PARITY_EN adds one even-parity bit per byte.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_sync #(
  parameter int DEPTH      = 128,
  parameter int ADDR_W     = 32,
  parameter int CLEAR_INIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic             misalign;
  logic             wr_en;
  logic             clr_en;
  logic [3:0]       mask;
  logic [31:0]      wdata_rep;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic             par_bad;
  logic             unused_addr_bits;

  // Address bits above the array span alias back onto it.
  assign idx              = req_addr[IDX_W+1:2];
  assign lane             = req_addr[1:0];
  assign unused_addr_bits = ^req_addr[ADDR_W-1:IDX_W+2];

  assign req_ready = (state == ST_RUN) && !rst;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we && !misalign;
  assign clr_en    = (state == ST_CLEAR) && !rst;
  assign rd_word   = mem[idx];
  assign ld_byte   = rd_word[{lane, 3'b000} +: 8];
  assign ld_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    misalign  = 1'b0;
    mask      = 4'h0;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        mask      = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        misalign  = lane[0];
        mask      = 4'b0011 << {lane[1], 1'b0};
        wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        misalign  = (lane != 2'b00);
        mask      = 4'hF;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_data = rd_word;
    case (req_size)
      SZ_BYTE: ld_data = {{24{!req_unsigned && ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{!req_unsigned && ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_INIT != 0) ? ST_CLEAR : ST_RUN;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == IDX_W'(DEPTH - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) begin
          mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] rd_par;
  logic [3:0] calc_par;
  logic [3:0] wr_par;

  for (genvar g = 0; g < 4; g++) begin : g_lane_par
    assign calc_par[g] = ^rd_word[8*g +: 8];
    assign wr_par[g]   = ^wdata_rep[8*g +: 8];
  end

  assign rd_par  = par_mem[idx];
  // Only the lanes actually read can flag a fault.
  assign par_bad = |((rd_par ^ calc_par) & mask);

  always_ff @(posedge clk) begin
    if (clr_en) begin
      par_mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l]) begin
          par_mem[idx][l] <= wr_par[l];
        end
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept && (!req_we || misalign);
      rsp_err   <= accept && (misalign || (!req_we && par_bad));
      rsp_rdata <= (accept && !req_we && !misalign) ? ld_data : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_sync
// Purpose  : Self-checking bench for data_memory_sync against a byte-array
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_sync;

  localparam int DEPTH      = 128;
  localparam int ADDR_W     = 32;
  localparam int CLEAR_INIT = 1;
  localparam int NBYTES     = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_memory_sync #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .CLEAR_INIT (CLEAR_INIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: little-endian byte array plus per-byte parity-corruption flags
  byte unsigned ref_mem [NBYTES];
  bit           ref_bad [NBYTES];
  bit           ref_run = 1'b0;
  int           ref_clr_left = 0;
  bit           exp_valid;
  bit           exp_err;
  logic [31:0]  exp_rdata;

  // One clock: drive at the falling edge, check, advance model, check response.
  task automatic cycle(input bit r, input bit v, input bit we, input logic [1:0] sz,
                       input bit uns, input logic [31:0] a, input logic [31:0] wd);
    bit          rdy, acc, err, bad;
    int          ba;
    logic [31:0] ld;
    rst = r; req_valid = v; req_we = we; req_size = sz;
    req_unsigned = uns; req_addr = a; req_wdata = wd;
    rdy = ref_run && !r;
    #1;
    check_eq("req_ready", {31'b0, req_ready}, {31'b0, rdy});
    acc = v && rdy;
    ba  = int'(a % NBYTES);
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    bad = 1'b0;
    ld  = '0;
    if (acc && !we && !err) begin
      case (sz)
        2'd0: begin
          ld  = 32'(ref_mem[ba]);
          bad = ref_bad[ba];
          if (!uns && ld[7]) ld = ld | 32'hFFFF_FF00;
        end
        2'd1: begin
          ld  = 32'({ref_mem[ba+1], ref_mem[ba]});
          bad = ref_bad[ba] | ref_bad[ba+1];
          if (!uns && ld[15]) ld = ld | 32'hFFFF_0000;
        end
        default: begin
          ld  = {ref_mem[ba+3], ref_mem[ba+2], ref_mem[ba+1], ref_mem[ba]};
          bad = ref_bad[ba] | ref_bad[ba+1] | ref_bad[ba+2] | ref_bad[ba+3];
        end
      endcase
    end
    exp_valid = acc && (err || !we);
    exp_err   = exp_valid && (err || bad);
    exp_rdata = (exp_valid && !err) ? ld : 32'h0;
    if (acc && we && !err) begin
      case (sz)
        2'd0: begin ref_mem[ba] = wd[7:0]; ref_bad[ba] = 1'b0; end
        2'd1: for (int k = 0; k < 2; k++) begin ref_mem[ba+k] = wd[8*k +: 8]; ref_bad[ba+k] = 1'b0; end
        default: for (int k = 0; k < 4; k++) begin ref_mem[ba+k] = wd[8*k +: 8]; ref_bad[ba+k] = 1'b0; end
      endcase
    end
    if (r) begin
      ref_run      = (CLEAR_INIT == 0);
      ref_clr_left = DEPTH;
    end else if (!ref_run) begin
      ref_clr_left--;
      if (ref_clr_left == 0) begin
        ref_run = 1'b1;
        for (int k = 0; k < NBYTES; k++) begin ref_mem[k] = 8'h00; ref_bad[k] = 1'b0; end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, sz, 1'b0, a, d);
  endtask

  task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    cycle(1'b0, 1'b1, 1'b0, sz, uns, a, 32'h0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] sum;
    @(negedge clk);

    // Reset and clear sweep
    do_reset();
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", {31'b0, rsp_err}, 32'h0);
    repeat (DEPTH) idle();
    check_eq("t1_ready", {31'b0, req_ready}, 32'h1);
    ld(2'd2, 1'b0, 32'h7C);
    check_eq("t1_ld7c", rsp_rdata, 32'h0);

    // Word stores and readback
    st(2'd2, 32'h50, 32'hA3);
    st(2'd2, 32'h54, 32'h27);
    st(2'd2, 32'h58, 32'h79);
    st(2'd2, 32'h5C, 32'h115);
    ld(2'd2, 1'b0, 32'h50); check_eq("t2_50", rsp_rdata, 32'hA3);
    ld(2'd2, 1'b0, 32'h54); check_eq("t2_54", rsp_rdata, 32'h27);
    ld(2'd2, 1'b0, 32'h58); check_eq("t2_58", rsp_rdata, 32'h79);
    ld(2'd2, 1'b0, 32'h5C); check_eq("t2_5c", rsp_rdata, 32'h115);
    sum = 32'hA3 + 32'h27 + 32'h79 + 32'h115;
    st(2'd2, 32'h60, sum);
    ld(2'd2, 1'b0, 32'h60); check_eq("t2_sum", rsp_rdata, 32'h258);

    // Byte store into a word, signed/unsigned byte loads
    st(2'd2, 32'h10, 32'h1122_3344);
    st(2'd0, 32'h12, 32'hFF);
    ld(2'd2, 1'b0, 32'h10); check_eq("t3_word", rsp_rdata, 32'h11FF_3344);
    ld(2'd0, 1'b0, 32'h12); check_eq("t3_sbyte", rsp_rdata, 32'hFFFF_FFFF);
    ld(2'd0, 1'b1, 32'h12); check_eq("t3_ubyte", rsp_rdata, 32'h0000_00FF);
    ld(2'd1, 1'b0, 32'h12); check_eq("t3_shalf", rsp_rdata, 32'h0000_11FF);

    // Error cases
    ld(2'd1, 1'b0, 32'h11);
    check_eq("t4_half_err", {31'b0, rsp_err}, 32'h1);
    check_eq("t4_half_data", rsp_rdata, 32'h0);
    st(2'd2, 32'h12, 32'hDEAD_BEEF);
    check_eq("t4_st_err", {31'b0, rsp_err}, 32'h1);
    ld(2'd2, 1'b0, 32'h10); check_eq("t4_unchanged", rsp_rdata, 32'h11FF_3344);
    ld(2'd3, 1'b0, 32'h10);
    check_eq("t4_size3", {31'b0, rsp_err}, 32'h1);
    st(2'd3, 32'h10, 32'h0);
    ld(2'd2, 1'b0, 32'h8000_0010); check_eq("t4_wrap", rsp_rdata, 32'h11FF_3344);

    // Back-to-back loads, then reset on the second response cycle
    ld(2'd2, 1'b0, 32'h50); check_eq("t5_r0", rsp_rdata, 32'hA3);
    ld(2'd2, 1'b0, 32'h54); check_eq("t5_r1", rsp_rdata, 32'h27);
    ld(2'd2, 1'b0, 32'h58); check_eq("t5_r2", rsp_rdata, 32'h79);
    ld(2'd2, 1'b0, 32'h50);
    ld(2'd2, 1'b0, 32'h54);
    cycle(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h58, 32'h0);
    check_eq("t5_drop", {31'b0, rsp_valid}, 32'h0);
    repeat (DEPTH) idle();
    ld(2'd2, 1'b0, 32'h50); check_eq("t5_cleared", rsp_rdata, 32'h0);

`ifdef DMEM_PARITY_EN
    st(2'd2, 32'h20, 32'hCAFE_BABE);
    dut.par_mem[8][1] = ~dut.par_mem[8][1];
    ref_bad[32'h21] = 1'b1;
    ld(2'd2, 1'b0, 32'h20);
    check_eq("t6_word_err", {31'b0, rsp_err}, 32'h1);
    ld(2'd0, 1'b0, 32'h20);
    check_eq("t6_byte_err", {31'b0, rsp_err}, 32'h0);
    check_eq("t6_byte", rsp_rdata, 32'hFFFF_FFBE);
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit          r, v, we, uns;
      logic [1:0]  sz;
      logic [31:0] a;
      r   = ($urandom_range(0, 499) == 0);
      v   = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1) == 1;
      uns = $urandom_range(0, 1) == 1;
      sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 63));
      cycle(r, v, we, sz, uns, a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
